program_counter_unit: RTL and testbench

- Parametrised next-generation program counter for the CPU fetch stage.
- Holds the architectural PC and advances it by a fixed increment each cycle.
- Supports stall, branch/jump redirect, trap vectoring, and a small circular return-address stack (RAS) for call/return.
- Feeds the instruction-memory address; redirect, call, ret and trap come from decode/execute and control.

---
 rtl/program_counter_unit.sv | 100 ++++++++++
 tb/tb_program_counter_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter_unit.sv
// Fetch-stage program counter: sequential advance, stall, redirect, trap vectoring
// and a circular return-address stack for call/return prediction.
module program_counter_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
    parameter int unsigned      INC          = 4,
    parameter int unsigned      RAS_DEPTH    = 4,
    localparam int unsigned     CNT_W        = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             trap,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic [CNT_W-1:0] ras_count,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ret_miss
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam logic [CNT_W-1:0] COUNT_FULL = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] top_idx;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ret_miss_q, ret_miss_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic             ras_nonempty;

    assign pc_plus      = pc_q + WIDTH'(INC);
    assign top_idx      = ptr_q - PTR_W'(1);
    assign ras_nonempty = (count_q != '0);

    assign pc        = pc_q;
    assign ras_count = count_q;
    assign ras_empty = (count_q == '0);
    assign ras_full  = (count_q == COUNT_FULL);
    assign ret_miss  = ret_miss_q;

    always_comb begin
        pc_d       = pc_q;
        ptr_d      = ptr_q;
        count_d    = count_q;
        ras_d      = ras_q;
        ret_miss_d = 1'b0;

        if (trap) begin
            pc_d = TRAP_VECTOR;
        end else if (redirect_valid || !stall) begin
            // A redirect overrides stall, and the RAS still acts on call/ret alongside it.
            if (redirect_valid) begin
                pc_d = redirect_target;
            end else if (ret && ras_nonempty) begin
                pc_d = ras_q[top_idx];
            end else begin
                pc_d = pc_plus;
            end

            if (call && ret && ras_nonempty) begin
                ras_d[top_idx] = pc_plus;
            end else if (call) begin
                ras_d[ptr_q] = pc_plus;
                ptr_d        = ptr_q + PTR_W'(1);
                if (count_q != COUNT_FULL) begin
                    count_d = count_q + CNT_W'(1);
                end
            end else if (ret && ras_nonempty) begin
                ptr_d   = top_idx;
                count_d = count_q - CNT_W'(1);
            end

            ret_miss_d = ret && !ras_nonempty;
        end
    end

    always_ff @(posedge clk) begin
        ras_q <= ras_d;
        if (reset) begin
            pc_q       <= RESET_VECTOR;
            ptr_q      <= '0;
            count_q    <= '0;
            ret_miss_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            ret_miss_q <= ret_miss_d;
        end
    end

endmodule

// File: tb/tb_program_counter_unit.sv
// Bench for program_counter_unit: directed scenario with literal expectations, then
// randomized traffic compared every cycle against a queue-based return-stack model.
module tb_program_counter_unit;

    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam logic [31:0] TV = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        trap = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [2:0]  ras_count;
    logic        ras_empty;
    logic        ras_full;
    logic        ret_miss;

    int checks = 0;
    int failures = 0;

    program_counter_unit #(
        .WIDTH(32),
        .RESET_VECTOR(RV),
        .TRAP_VECTOR(TV),
        .INC(4),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .trap(trap),
        .redirect_valid(redirect_valid),
        .redirect_target(redirect_target),
        .call(call),
        .ret(ret),
        .pc(pc),
        .pc_plus(pc_plus),
        .ras_count(ras_count),
        .ras_empty(ras_empty),
        .ras_full(ras_full),
        .ret_miss(ret_miss)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the return stack is a queue whose back is the top;
    // overflow drops the oldest element from the front.
    logic [31:0] m_pc;
    logic        m_miss;
    logic [31:0] m_ras[$];
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        logic [31:0] seq;
        bit          has;
        if (reset) begin
            m_pc = RV;
            m_miss = 1'b0;
            m_ras.delete();
            model_valid = 1'b1;
        end else if (trap) begin
            m_pc = TV;
            m_miss = 1'b0;
        end else if (stall && !redirect_valid) begin
            m_miss = 1'b0;
        end else begin
            seq = m_pc + 32'd4;
            has = (m_ras.size() > 0);
            if (redirect_valid) m_pc = redirect_target;
            else if (ret && has) m_pc = m_ras[$];
            else m_pc = seq;
            if (call && ret && has) begin
                m_ras[m_ras.size() - 1] = seq;
            end else if (call) begin
                m_ras.push_back(seq);
                if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
            end else if (ret && has) begin
                void'(m_ras.pop_back());
            end
            m_miss = ret && !has;
        end
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("pc", pc, m_pc);
            check("pc_plus", pc_plus, m_pc + 32'd4);
            check("ras_count", {29'd0, ras_count}, m_ras.size());
            check("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
            check("ras_full", {31'd0, ras_full}, {31'd0, m_ras.size() == DEPTH});
            check("ret_miss", {31'd0, ret_miss}, {31'd0, m_miss});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset = 1'b0; stall = 1'b0; trap = 1'b0;
        redirect_valid = 1'b0; call = 1'b0; ret = 1'b0;
    endtask

    task automatic jump(input logic [31:0] t);
        redirect_valid = 1'b1; redirect_target = t;
        cyc();
        redirect_valid = 1'b0;
    endtask

    initial begin
        cyc();
        idle();
        check("reset_pc", pc, 32'h0);
        check("reset_count", {29'd0, ras_count}, 32'd0);
        check("reset_empty", {31'd0, ras_empty}, 32'd1);
        check("reset_miss", {31'd0, ret_miss}, 32'd0);
        cyc(); cyc();
        check("free_run_8", pc, 32'h8);
        stall = 1'b1;
        cyc(); cyc();
        check("stall_hold", pc, 32'h8);
        stall = 1'b0;
        cyc();
        check("stall_release", pc, 32'hC);
        stall = 1'b1;
        jump(32'h40);
        stall = 1'b0;
        check("redirect_in_stall", pc, 32'h40);

        jump(32'h10);
        call = 1'b1;
        jump(32'h200);
        call = 1'b0;
        check("call_redirect_pc", pc, 32'h200);
        check("call_count", {29'd0, ras_count}, 32'd1);
        cyc();
        ret = 1'b1;
        cyc();
        ret = 1'b0;
        check("ret_pc", pc, 32'h14);
        check("ret_count", {29'd0, ras_count}, 32'd0);

        jump(32'h0);
        for (int k = 1; k <= 5; k++) begin
            call = 1'b1;
            jump(32'h100 * k);
        end
        call = 1'b0;
        check("nested_full", {31'd0, ras_full}, 32'd1);
        check("nested_count", {29'd0, ras_count}, 32'd4);
        for (int k = 4; k >= 1; k--) begin
            ret = 1'b1;
            cyc();
            check("nested_ret", pc, 32'h100 * k + 32'h4);
        end
        cyc();
        ret = 1'b0;
        check("empty_ret_pc", pc, 32'h108);
        check("empty_ret_miss", {31'd0, ret_miss}, 32'd1);
        cyc();
        check("miss_one_cycle", {31'd0, ret_miss}, 32'd0);

        call = 1'b1;
        cyc();
        trap = 1'b1;
        jump(32'h777);
        trap = 1'b0; call = 1'b0;
        check("trap_pc", pc, 32'h100);
        check("trap_ras_kept", {29'd0, ras_count}, 32'd1);
        reset = 1'b1; trap = 1'b1;
        cyc();
        idle();
        check("reset_over_trap_pc", pc, 32'h0);
        check("reset_over_trap_count", {29'd0, ras_count}, 32'd0);

        jump(32'hFFFF_FFFC);
        check("wrap_pc_plus", pc_plus, 32'h0);
        cyc();
        check("wrap_pc", pc, 32'h0);

        jump(32'h100);
        call = 1'b1;
        jump(32'h500);
        ret = 1'b1;
        cyc();
        call = 1'b0;
        check("tail_pc", pc, 32'h104);
        check("tail_count", {29'd0, ras_count}, 32'd1);
        cyc();
        ret = 1'b0;
        check("tail_top_entry", pc, 32'h504);
        call = 1'b1; ret = 1'b1;
        cyc();
        call = 1'b0; ret = 1'b0;
        check("tail_empty_pc", pc, 32'h508);
        check("tail_empty_count", {29'd0, ras_count}, 32'd1);
        check("tail_empty_miss", {31'd0, ret_miss}, 32'd1);

        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(63) == 0);
            trap = ($urandom_range(15) == 0);
            stall = ($urandom_range(4) == 0);
            redirect_valid = ($urandom_range(5) == 0);
            redirect_target = ($urandom_range(7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            call = ($urandom_range(3) == 0);
            ret = ($urandom_range(3) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
